// File: rtl/input_ram_writer_pkg.sv
// Shared constants and types for the SNN input-image path: image geometry,
// RAM address width and the UART-to-RAM writer state encoding.
package input_ram_writer_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIX_ADDR_W = 10;
  localparam int IMG_BYTES  = NUM_PIXELS / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } wr_state_e;

  // Flat RAM address of bit `bit_idx` of image byte `byte_idx` (LSB-first unpacking).
  function automatic int unsigned pixel_addr(input int unsigned byte_idx,
                                             input int unsigned bit_idx);
    return (byte_idx * 8) + bit_idx;
  endfunction

endpackage

// File: rtl/input_ram_writer_if.sv
// Bundle between the UART receiver, the image writer and the input RAM write port.
interface input_ram_writer_if #(
  parameter int ADDR_W = 10
) ();

  // rx_rdy is a one-cycle valid strobe qualifying rx_data; there is no ready
  // back to the receiver, so a byte the writer cannot hold is dropped and
  // flagged on the sticky overrun output.
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              wdata;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output rx_data, rx_rdy,
    input  we, waddr, wdata, busy, done, overrun
  );

  modport slave (
    input  rx_data, rx_rdy,
    output we, waddr, wdata, busy, done, overrun
  );

endinterface

// File: rtl/input_ram_writer.sv
// Unpacks UART image bytes LSB-first into one-bit writes of the 784-entry
// input RAM, one pixel per clock, with a one-byte holding buffer.
module input_ram_writer #(
  parameter int NUM_PIXELS = input_ram_writer_pkg::NUM_PIXELS,
  parameter int ADDR_W     = input_ram_writer_pkg::PIX_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input_ram_writer_if.slave              bus,
  output input_ram_writer_pkg::wr_state_e dbg_state
);
  import input_ram_writer_pkg::*;

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIXELS - 1);

  wr_state_e         state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              overrun_q, overrun_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              in_shift;
  logic              active;
  logic [7:0]        cur_byte;
  logic [2:0]        cur_idx;
  logic              last_pix;

  // In IDLE a strobed byte is consumed straight from rx_data so its bit 0 is
  // written on the very next cycle; in SHIFT the shift register is the source.
  always_comb begin
    in_shift = (state_q == ST_SHIFT);
    active   = in_shift || bus.rx_rdy;
    cur_byte = in_shift ? shreg_q : bus.rx_data;
    cur_idx  = in_shift ? bcnt_q : 3'd0;
    last_pix = (pcnt_q == PIX_LAST);

    state_d    = state_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    pcnt_d     = pcnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;

    if (active) begin
      we_d    = 1'b1;
      wdata_d = cur_byte[0];
      waddr_d = pcnt_q;
      done_d  = last_pix;
      pcnt_d  = last_pix ? '0 : pcnt_q + 1'b1;
      shreg_d = {1'b0, cur_byte[7:1]};
      bcnt_d  = cur_idx + 3'd1;
      state_d = ST_SHIFT;

      if (cur_idx == 3'd7) begin
        // Last bit of the byte: chain the next byte with no idle cycle.
        bcnt_d = 3'd0;
        if (pend_vld_q) begin
          shreg_d    = pend_q;
          pend_vld_d = bus.rx_rdy;
          if (bus.rx_rdy) begin
            pend_d = bus.rx_data;
          end
        end else if (bus.rx_rdy) begin
          shreg_d = bus.rx_data;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (in_shift && bus.rx_rdy) begin
        if (!pend_vld_q) begin
          pend_d     = bus.rx_data;
          pend_vld_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    // Stays high through the done cycle and drops one cycle later if nothing is queued.
    busy_d = active || (pcnt_d != '0) || pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      pcnt_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      pcnt_q     <= pcnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_input_ram_writer.sv
// Directed bench for input_ram_writer: scoreboard of expected {addr,bit}
// writes, popped by a write monitor, plus directed status checks.
module tb_input_ram_writer;
  import input_ram_writer_pkg::*;

  localparam int AW = 10;
  localparam int NP = 784;

  logic      clk;
  logic      rst;
  wr_state_e dbg_state;

  input_ram_writer_if #(.ADDR_W(AW)) bus ();

  input_ram_writer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [AW:0] exp_q[$];
  int          exp_pcnt = 0;
  logic        ram_model [0:NP-1];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          first0_cyc = 0;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [AW:0] e;
    if (bus.we) begin
      wr_cnt++;
      if (int'(bus.waddr) < NP) ram_model[bus.waddr] = bus.wdata;
      if (bus.waddr == '0) first0_cyc = cyc;
      if (bus.done) begin
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        done_cnt++;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(bus.waddr), 32'(e[AW:1]));
        chk("wdata", 32'(bus.wdata), 32'(e[0]));
        chk("done_on_write", 32'(bus.done), 32'(e[AW:1] == AW'(NP - 1)));
      end
    end else begin
      chk("done_without_we", 32'(bus.done), 32'd0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({AW'(exp_pcnt), b[i]});
      exp_pcnt = (exp_pcnt == NP - 1) ? 0 : exp_pcnt + 1;
    end
  endtask

  // Strobes one byte for a single cycle; `kept` says whether it should be written.
  task automatic send(input logic [7:0] b, input bit kept);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    if (kept) push_byte(b);
    tick();
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"},      32'(bus.we), 32'd0);
    chk({tag, "_waddr"},   32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"},   32'(bus.wdata), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_state"},   32'(dbg_state), 32'(ST_IDLE));
  endtask

  // One reset cycle; optionally with a byte strobed in the same cycle.
  task automatic do_reset(input string tag, input bit with_byte);
    rst = 1'b1;
    if (with_byte) begin
      bus.rx_data = 8'hFF;
      bus.rx_rdy  = 1'b1;
    end
    tick();
    bus.rx_rdy = 1'b0;
    exp_q.delete();
    exp_pcnt = 0;
    check_reset_values(tag);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.we) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_we_low", 32'(bus.we), 32'd0);
  endtask

  initial begin
    int wr0, dn0, span;
    logic [7:0] b, got;

    rst         = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_rdy  = 1'b0;
    idle(2);
    do_reset("reset", 1'b0);
    tick();
    check_reset_values("post_reset");

    // single byte 0xA5: latency, address walk, busy held afterwards
    send(8'hA5, 1'b1);
    chk("a5_first_we", 32'(bus.we), 32'd1);
    chk("a5_first_addr", 32'(bus.waddr), 32'd0);
    chk("a5_first_busy", 32'(bus.busy), 32'd1);
    idle(7);
    chk("a5_last_we", 32'(bus.we), 32'd1);
    chk("a5_last_addr", 32'(bus.waddr), 32'd7);
    idle(1);
    chk("a5_idle_we", 32'(bus.we), 32'd0);
    chk("a5_idle_busy", 32'(bus.busy), 32'd1);
    chk("a5_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // full image, one byte every 8 cycles
    do_reset("img_reset", 1'b0);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    for (int k = 1; k <= IMG_BYTES; k++) begin
      send(8'(k), 1'b1);
      idle(7);
    end
    drain();
    span = last_done_cyc - first0_cyc + 1;
    chk("img_write_count", 32'(wr_cnt - wr0), 32'(NP));
    chk("img_done_count", 32'(done_cnt - dn0), 32'd1);
    chk("img_contiguous_span", 32'(span), 32'(NP));
    chk("img_busy_after", 32'(bus.busy), 32'd0);
    chk("img_overrun", 32'(bus.overrun), 32'd0);
    for (int k = 0; k < IMG_BYTES; k++) begin
      for (int i = 0; i < 8; i++) got[i] = ram_model[pixel_addr(k, i)];
      b = 8'(k + 1);
      chk("img_ram_byte", 32'(got), 32'(b));
    end

    // early byte held in pend, plus a byte landing exactly on the last bit
    do_reset("pend_reset", 1'b0);
    wr0 = wr_cnt;
    send(8'h3C, 1'b1);
    idle(2);
    send(8'hC3, 1'b1);
    idle(7);
    send(8'h5A, 1'b1);
    drain();
    send(8'h96, 1'b1);
    idle(6);
    send(8'h69, 1'b1);
    drain();
    chk("pend_write_count", 32'(wr_cnt - wr0), 32'd40);
    chk("pend_overrun", 32'(bus.overrun), 32'd0);

    // three bytes on consecutive cycles: third dropped, overrun sticky
    do_reset("ovr_reset", 1'b0);
    wr0 = wr_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    drain();
    idle(5);
    chk("ovr_write_count", 32'(wr_cnt - wr0), 32'd16);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // reset mid-image after 40 random bytes, then byte 0xFF restarts at 0
    do_reset("mid_reset0", 1'b0);
    for (int k = 0; k < 40; k++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      idle(7);
    end
    send(8'($urandom_range(0, 255)), 1'b1);
    idle(3);
    do_reset("mid_reset", 1'b0);
    wr0 = wr_cnt;
    send(8'hFF, 1'b1);
    drain();
    chk("mid_restart_count", 32'(wr_cnt - wr0), 32'd8);

    // byte strobed together with rst is discarded
    wr0 = wr_cnt;
    do_reset("rst_with_byte", 1'b1);
    idle(3);
    chk("rst_byte_discarded", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_byte_busy", 32'(bus.busy), 32'd0);

    // two images back-to-back
    dn0 = done_cnt;
    for (int k = 0; k < 2 * IMG_BYTES; k++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      idle(7);
    end
    drain();
    chk("two_img_done_count", 32'(done_cnt - dn0), 32'd2);
    chk("two_img_done_gap", 32'(last_done_cyc - prev_done_cyc), 32'(NP));
    chk("two_img_busy_after", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
